sdram_capture_writer: RTL
=========================

SDRAM_CAPTURE_WRITER -- requirements
Module: sdram_capture_writer

Interface
REQ-001 Parameters: ADDR_W 25 (Avalon word address width); DATA_W 16 (sample width); FIFO_AW 4 (elastic FIFO depth = 2**FIFO_AW = 16); BASE_ADDR 0 (first capture address); TOP_ADDR 25'h1FFFFFF (last capture address, inclusive); OFFSET_BIN 1 (1 = input is offset-binary, convert by inverting MSB).
REQ-002 Ports, clock and reset first; single clock M100CLK, reset lock asynchronous active-low.
REQ-003 M100CLK  in  1  system clock, all logic on rising edge.
REQ-004 lock  in  1  asynchronous active-low reset (PLL lock).
REQ-005 enable  in  1  capture enable, level.
REQ-006 adc_valid  in  1  sample strobe, one sample per high cycle.
REQ-007 adc_data  in  DATA_W  ADC sample.
REQ-008 av_address  out  ADDR_W  Avalon write address.
REQ-009 av_writedata  out  DATA_W  Avalon write data.
REQ-010 av_write  out  1  Avalon write request, active-high.
REQ-011 av_byteenable  out  2  constant 2'b11 when av_write=1, else 2'b00.
REQ-012 av_chipenable  out  1  1 whenever state != IDLE.
REQ-013 av_waitrequest  in  1  slave stall, active-high.
REQ-014 wr_ptr  out  ADDR_W  address of the next word to be written.
REQ-015 fifo_level  out  FIFO_AW+1  FIFO occupancy, 0..16.
REQ-016 overflow  out  1  sticky, a sample was dropped.
REQ-017 wrapped  out  1  sticky, wr_ptr has wrapped TOP_ADDR -> BASE_ADDR at least once.
REQ-018 busy  out  1  1 when state is RUN or DRAIN.

Function
REQ-019 Main FSM states IDLE, RUN and DRAIN. IDLE->RUN when enable=1. RUN->DRAIN when enable=0. DRAIN->IDLE when the FIFO is empty and no write is pending. DRAIN->RUN when enable=1.
REQ-020 Samples are accepted only in RUN. A sample is pushed when adc_valid=1 and the FIFO is not full. Samples with adc_valid=1 in IDLE or DRAIN are ignored without setting overflow.
REQ-021 Conversion when pushed: if OFFSET_BIN=1, store {~adc_data[15], adc_data[14:0]}; otherwise store adc_data unchanged.
REQ-022 A push with the FIFO full drops the sample, leaves the FIFO unchanged and sets overflow=1 on the next edge. overflow stays set until reset.
REQ-023 Avalon write: when av_write=0 and the FIFO is non-empty, the next edge pops the head and drives av_write=1, av_writedata=head and av_address=wr_ptr.
REQ-024 While av_write=1 and av_waitrequest=1, av_address, av_writedata and av_write are held stable.
REQ-025 The write is accepted on an edge where av_write=1 and av_waitrequest=0. On acceptance, wr_ptr advances. If the FIFO is non-empty, the next word is issued on that same edge (back-to-back, one word per cycle); otherwise av_write drops to 0.
REQ-026 Address advance: wr_ptr = wr_ptr+1, except when wr_ptr == TOP_ADDR, where wr_ptr becomes BASE_ADDR and wrapped is set to 1 (sticky).
REQ-027 Latency: a sample pushed at edge N into an empty FIFO with av_write=0 appears on av_write/av_writedata at edge N+1.
REQ-028 Simultaneous push and pop on the same edge keeps fifo_level unchanged. A push while full is dropped even if a pop happens on the same edge; full is evaluated before the pop.
REQ-029 fifo_level counts only words still in the FIFO; a word held on the Avalon outputs is not counted.
REQ-030 enable=0 never aborts a pending write. DRAIN drains all words still in the FIFO to SDRAM.
REQ-031 A new IDLE->RUN transition does not reset wr_ptr; capture continues from the current address.

Reset
REQ-032 While lock=0, asynchronously: state=IDLE, FIFO empty, fifo_level=0, av_write=0, av_address=0, av_writedata=0, av_byteenable=0, av_chipenable=0, wr_ptr=BASE_ADDR, overflow=0, wrapped=0, busy=0.
REQ-033 Reset asserted mid-write abandons that write immediately: av_write=0 at once, with no hold for av_waitrequest. FIFO contents are lost.
REQ-034 After lock rises, no output changes until the first rising edge of M100CLK.

Verification
REQ-035 Streaming: enable=1, adc_valid=1 for 8 cycles with adc_data 16'h8000..16'h8007, av_waitrequest=0 -> 8 writes at addresses 0..7 with data 16'h0000..16'h0007, wr_ptr=8, fifo_level ends at 0.
REQ-036 Stall: av_waitrequest=1 for 20 cycles while 20 samples arrive -> the first word is held stable, fifo_level saturates at 16, overflow=1, and exactly 17 words are written after the stall releases.
REQ-037 Wrap: TOP_ADDR=25'd5, BASE_ADDR=25'd2, 6 samples -> addresses 2,3,4,5,2,3 and wrapped=1 after the fourth acceptance.
REQ-038 Drain: enable drops with fifo_level=5 -> state is DRAIN with busy=1, 5 writes complete, then IDLE with busy=0. adc_valid during DRAIN has no effect on the FIFO or overflow.
REQ-039 Reset mid-write: lock=0 while av_write=1 and av_waitrequest=1 -> av_write=0 and wr_ptr=BASE_ADDR without waiting for a clock edge, and all sticky flags are cleared.
REQ-040 OFFSET_BIN=0: adc_data 16'h1234 -> av_writedata 16'h1234.

Source files
------------

// File: rtl/sdram_capture_writer_if.sv
// sdram_capture_writer_if: ADC sample input and Avalon-MM write master signals
interface sdram_capture_writer_if #(
    parameter int ADDR_W = 25,
    parameter int DATA_W = 16
) ();
    logic              adc_valid;
    logic [DATA_W-1:0] adc_data;
    logic [ADDR_W-1:0] av_address;
    logic [DATA_W-1:0] av_writedata;
    logic              av_write;
    logic [1:0]        av_byteenable;
    logic              av_chipenable;
    logic              av_waitrequest;

    modport master (
        input  adc_valid, adc_data, av_waitrequest,
        output av_address, av_writedata, av_write, av_byteenable, av_chipenable
    );

    modport slave (
        output adc_valid, adc_data, av_waitrequest,
        input  av_address, av_writedata, av_write, av_byteenable, av_chipenable
    );
endinterface

// File: rtl/sdram_capture_writer.sv
// sdram_capture_writer: buffers ADC samples in an elastic FIFO and streams them to SDRAM over Avalon-MM
module sdram_capture_writer #(
    parameter int                ADDR_W     = 25,
    parameter int                DATA_W     = 16,
    parameter int                FIFO_AW    = 4,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
    parameter logic [ADDR_W-1:0] TOP_ADDR   = {ADDR_W{1'b1}},
    parameter int                OFFSET_BIN = 1
) (
    input  logic                  M100CLK,
    input  logic                  lock,
    input  logic                  enable,
    sdram_capture_writer_if.master bus,
    output logic [ADDR_W-1:0]     wr_ptr,
    output logic [FIFO_AW:0]      fifo_level,
    output logic                  overflow,
    output logic                  wrapped,
    output logic                  busy
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t              r_state, w_state_nx;
    logic [DATA_W-1:0]   r_mem [2**FIFO_AW];
    logic [FIFO_AW-1:0]  r_rd, r_wi;
    logic [FIFO_AW:0]    r_level;
    logic                r_av_write;
    logic [ADDR_W-1:0]   r_av_address, r_ptr;
    logic [DATA_W-1:0]   r_av_data;
    logic                r_ovf, r_wrap;
    logic                w_full, w_empty, w_push, w_drop, w_accept, w_pop, w_busy, w_chip;
    logic [ADDR_W-1:0]   w_ptr_nx;
    logic [DATA_W-1:0]   w_conv;

    // Level MSB is set only at exactly 2**FIFO_AW words, i.e. full
    assign w_full   = r_level[FIFO_AW];
    assign w_empty  = r_level == '0;
    assign w_push   = r_state == RUN && bus.adc_valid && !w_full;
    assign w_drop   = r_state == RUN && bus.adc_valid && w_full;
    assign w_accept = r_av_write && !bus.av_waitrequest;
    // A word is popped into the bus registers when they are free or being freed this edge
    assign w_pop    = !w_empty && (!r_av_write || w_accept);
    assign w_ptr_nx = !w_accept ? r_ptr : (r_ptr == TOP_ADDR ? BASE_ADDR : r_ptr + ADDR_W'(1));
    assign w_conv   = (OFFSET_BIN != 0) ? {~bus.adc_data[DATA_W-1], bus.adc_data[DATA_W-2:0]} : bus.adc_data;

    assign bus.av_address    = r_av_address;
    assign bus.av_writedata  = r_av_data;
    assign bus.av_write      = r_av_write;
    assign bus.av_byteenable = r_av_write ? 2'b11 : 2'b00;
    assign bus.av_chipenable = w_chip;
    assign wr_ptr            = r_ptr;
    assign fifo_level        = r_level;
    assign overflow          = r_ovf;
    assign wrapped           = r_wrap;
    assign busy              = w_busy;

    // Capture state register
    always_ff @(posedge M100CLK or negedge lock) begin
        if (!lock) r_state <= IDLE;
        else       r_state <= w_state_nx;
    end

    // Next state and state-decoded outputs; DRAIN only retires once FIFO and bus are both idle
    always_comb begin
        w_state_nx = r_state;
        w_busy     = r_state == RUN || r_state == DRAIN;
        w_chip     = r_state != IDLE;
        case (r_state)
            IDLE:    w_state_nx = enable ? RUN : IDLE;
            RUN:     w_state_nx = enable ? RUN : DRAIN;
            DRAIN:   w_state_nx = enable ? RUN : (w_empty && !r_av_write) ? IDLE : DRAIN;
            default: w_state_nx = IDLE;
        endcase
    end

    // FIFO storage; contents need no reset since the pointers define validity
    always_ff @(posedge M100CLK) begin
        if (w_push) r_mem[r_wi] <= w_conv;
    end

    // FIFO pointers, Avalon write registers, address counter and sticky flags
    always_ff @(posedge M100CLK or negedge lock) begin
        if (!lock) begin
            r_rd         <= '0;
            r_wi         <= '0;
            r_level      <= '0;
            r_av_write   <= 1'b0;
            r_av_address <= '0;
            r_av_data    <= '0;
            r_ptr        <= BASE_ADDR;
            r_ovf        <= 1'b0;
            r_wrap       <= 1'b0;
        end else begin
            if (w_push) r_wi <= r_wi + FIFO_AW'(1);
            r_level <= r_level + (FIFO_AW+1)'(w_push) - (FIFO_AW+1)'(w_pop);
            if (w_pop) begin
                r_rd         <= r_rd + FIFO_AW'(1);
                r_av_write   <= 1'b1;
                r_av_data    <= r_mem[r_rd];
                r_av_address <= w_ptr_nx;
            end else if (w_accept) begin
                r_av_write <= 1'b0;
            end
            r_ptr <= w_ptr_nx;
            if (w_drop) r_ovf <= 1'b1;
            if (w_accept && r_ptr == TOP_ADDR) r_wrap <= 1'b1;
        end
    end
endmodule
